des_block_packer: RTL and testbench

Byte-to-block packer that sits directly upstream of the 3DES datapath in the ECCDH3DES top. It accepts a byte stream with a valid/ready handshake and assembles bytes MSB-first into 64-bit plaintext blocks. Completed blocks are buffered in a small FIFO and presented on a valid/ready interface whose data/valid map onto the top's `raw_data` / `data_valid_in`. A flush input closes a partial block with padding.

---
 rtl/des_pkg.sv | 39 +++
 rtl/des_block_fifo.sv | 64 ++++++
 rtl/des_block_packer.sv | 102 ++++++++++
 tb/tb_des_block_packer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared types and padding helpers for the 3DES byte-to-block packer.
// `DES_PACKER_PKCS5_EN selects PKCS#5 padding; otherwise blocks are zero padded.
package des_pkg;

  localparam int BLOCK_W         = 64;
  localparam int BYTE_W          = 8;
  localparam int BYTES_PER_BLOCK = 8;
  localparam int IDX_W           = $clog2(BYTES_PER_BLOCK);

  typedef logic [BLOCK_W-1:0] block_t;
  typedef logic [BYTE_W-1:0]  byte_t;
  typedef logic [IDX_W-1:0]   idx_t;

  typedef enum logic {
    ST_FILL,
    ST_PAD
  } pack_state_e;

`ifdef DES_PACKER_PKCS5_EN
  localparam bit PKCS5_EN = 1'b1;
`else
  localparam bit PKCS5_EN = 1'b0;
`endif

  function automatic byte_t pad_byte(input idx_t idx);
    return PKCS5_EN ? byte_t'(BYTES_PER_BLOCK - int'(idx)) : '0;
  endfunction

  // Slots idx..7 are overwritten, so stale bytes from an earlier block never leak out.
  function automatic block_t pad_block(input block_t blk, input idx_t idx);
    block_t res;
    res = blk;
    for (int s = 0; s < BYTES_PER_BLOCK; s++) begin
      if (s >= int'(idx)) res[BLOCK_W-BYTE_W*(s+1) +: BYTE_W] = pad_byte(idx);
    end
    return res;
  endfunction

endpackage

// File: rtl/des_block_fifo.sv
// Show-ahead FIFO of 64-bit blocks with occupancy count; head reads as zero when empty.
module des_block_fifo
  import des_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  block_t                 push_data,
  input  logic                   pop,
  output block_t                 head_data,
  output logic                   head_valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  block_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               pop_fire;

  assign pop_fire = pop && (count_q != '0);

  // NOTE: an always_comb must assign every output on every path; defaults first prevent latches.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push)     wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_fire) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is left unreset; emptiness is tracked by count_q and masks stale entries.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_valid = (count_q != '0);
  assign head_data  = head_valid ? mem_q[rd_ptr_q] : '0;
  assign count      = count_q;

endmodule

// File: rtl/des_block_packer.sv
// Packs a byte stream MSB-first into 64-bit blocks for the 3DES datapath, with flush padding.
// `DES_PACKER_PKCS5_EN selects PKCS#5 padding; the default build zero pads.
module des_block_packer
  import des_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [BYTE_W-1:0]      byte_in,
  input  logic                   byte_valid,
  output logic                   byte_ready,
  input  logic                   flush,
  output logic [BLOCK_W-1:0]     block_data,
  output logic                   block_valid,
  input  logic                   block_ready,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   busy
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  pack_state_e state_q, state_d;
  idx_t        idx_q, idx_d;
  block_t      asm_q, asm_d;
  logic        push;
  block_t      push_data;
  logic        fifo_full;
  logic        pad_skip;

  assign fifo_full = (fifo_count == CNT_W'(DEPTH));
  // Zero padding has nothing to emit for an empty assembler.
  assign pad_skip  = (idx_q == '0) && !PKCS5_EN;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FILL;
      idx_q   <= '0;
      asm_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL: if (flush) state_d = ST_PAD;
      ST_PAD:  if (pad_skip || !fifo_full) state_d = ST_FILL;
      default: state_d = ST_FILL;
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    push       = 1'b0;
    push_data  = asm_q;
    idx_d      = idx_q;
    asm_d      = asm_q;
    case (state_q)
      ST_FILL: begin
        byte_ready = !((idx_q == idx_t'(BYTES_PER_BLOCK - 1)) && fifo_full);
        if (byte_valid && byte_ready) begin
          asm_d[BLOCK_W-BYTE_W*(int'(idx_q)+1) +: BYTE_W] = byte_in;
          if (idx_q == idx_t'(BYTES_PER_BLOCK - 1)) begin
            push      = 1'b1;
            push_data = asm_d;
            idx_d     = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_PAD: begin
        if (!pad_skip && !fifo_full) begin
          push      = 1'b1;
          push_data = pad_block(asm_q, idx_q);
          idx_d     = '0;
        end
      end
      default: ;
    endcase
  end

  assign busy = (idx_q != '0) || (state_q == ST_PAD);

  des_block_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_data  (push_data),
    .pop        (block_ready),
    .head_data  (block_data),
    .head_valid (block_valid),
    .count      (fifo_count)
  );

endmodule

// File: tb/tb_des_block_packer.sv
// Self-checking bench for des_block_packer: directed scenarios plus random traffic vs a queue model.
module tb_des_block_packer;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef DES_PACKER_PKCS5_EN
  localparam bit PKCS = 1'b1;
`else
  localparam bit PKCS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    byte_in = '0;
  logic          byte_valid = 1'b0;
  logic          byte_ready;
  logic          flush = 1'b0;
  logic [63:0]   block_data;
  logic          block_valid;
  logic          block_ready = 1'b0;
  logic [CW-1:0] fifo_count;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  // Reference model: pending bytes, pad request flag, expected FIFO contents.
  logic [7:0]  partial[$];
  bit          pad_pending;
  logic [63:0] exp_q[$];
  logic [63:0] want[$];
  logic        last_ready;

  des_block_packer #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .flush       (flush),
    .block_data  (block_data),
    .block_valid (block_valid),
    .block_ready (block_ready),
    .fifo_count  (fifo_count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk_block(input logic [7:0] base);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = {r[55:0], 8'(base + 8'(i))};
    return r;
  endfunction

  function automatic logic [63:0] model_pad();
    logic [63:0] r;
    int n;
    n = partial.size();
    r = '0;
    for (int i = 0; i < 8; i++) r = {r[55:0], (i < n) ? partial[i] : (PKCS ? 8'(8 - n) : 8'h00)};
    return r;
  endfunction

  // One clock cycle: drive, compare against the model, advance the model, cross the edge.
  task automatic cycle(input logic bv, input logic [7:0] b, input logic fl, input logic br,
                       output bit acc);
    bit rdy, pop, full;
    byte_valid  = bv;
    byte_in     = b;
    flush       = fl;
    block_ready = br;
    #1;
    rdy  = !pad_pending && !(partial.size() == 7 && exp_q.size() == DEPTH);
    full = (exp_q.size() == DEPTH);
    pop  = br && (exp_q.size() != 0);
    last_ready = byte_ready;
    check("byte_ready", 64'(byte_ready), 64'(rdy));
    check("block_valid", 64'(block_valid), 64'(exp_q.size() != 0));
    check("block_data", block_data, (exp_q.size() != 0) ? exp_q[0] : 64'h0);
    check("fifo_count", 64'(fifo_count), 64'(exp_q.size()));
    check("busy", 64'(busy), 64'(pad_pending || partial.size() != 0));
    if (pop && want.size() != 0) check("block_order", block_data, want.pop_front());
    acc = bv && rdy;
    if (pop) void'(exp_q.pop_front());
    if (!pad_pending) begin
      if (acc) begin
        partial.push_back(b);
        if (partial.size() == 8) begin
          exp_q.push_back(model_pad());
          partial.delete();
        end
      end
      if (fl) pad_pending = 1'b1;
    end else if (partial.size() == 0 && !PKCS) begin
      pad_pending = 1'b0;
    end else if (!full) begin
      exp_q.push_back(model_pad());
      partial.delete();
      pad_pending = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic br);
    bit acc;
    acc = 1'b0;
    for (int t = 0; t < 200 && !acc; t++) cycle(1'b1, b, 1'b0, br, acc);
    check("send_timeout", 64'(acc), 64'(1));
  endtask

  task automatic idle(input int n, input logic br);
    bit acc;
    for (int t = 0; t < n; t++) cycle(1'b0, 8'h00, 1'b0, br, acc);
  endtask

  task automatic drain();
    bit acc;
    int t;
    t = 0;
    while ((exp_q.size() != 0 || pad_pending) && t < 100) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b1, acc);
      t++;
    end
    check("drain_timeout", 64'(exp_q.size() != 0 || pad_pending), 64'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_byte_ready", 64'(byte_ready), 64'(1));
    check("rst_block_valid", 64'(block_valid), 64'(0));
    check("rst_block_data", block_data, 64'h0);
    check("rst_fifo_count", 64'(fifo_count), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    partial.delete();
    exp_q.delete();
    want.delete();
    pad_pending = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    bit acc;
    int low_cnt;
    logic [7:0] msg[8];
    msg = '{8'h64, 8'h65, 8'h61, 8'h64, 8'h62, 8'h65, 8'h65, 8'h66};
    pad_pending = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Single block streamed with the consumer ready.
    want.push_back(64'h6465616462656566);
    foreach (msg[i]) send(msg[i], 1'b1);
    drain();
    check("t1_count", 64'(fifo_count), 64'(0));

    // Back-pressure: 4 blocks fill the FIFO, byte 0x27 waits at slot 7.
    want.push_back(64'h0001020304050607);
    for (int k = 1; k < 5; k++) want.push_back(mk_block(8'(8 * k)));
    for (int i = 0; i < 39; i++) send(8'(i), 1'b0);
    cycle(1'b1, 8'h27, 1'b0, 1'b0, acc);
    check("t2_stall", 64'(acc), 64'(0));
    check("t2_full", 64'(fifo_count), 64'(DEPTH));
    send(8'h27, 1'b1);
    drain();

    // Partial block closed by flush; byte_ready drops for exactly one cycle.
    want.push_back(PKCS ? 64'hAABBCC0505050505 : 64'hAABBCC0000000000);
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    send(8'hCC, 1'b0);
    low_cnt = 0;
    cycle(1'b0, 8'h00, 1'b1, 1'b0, acc);
    if (!last_ready) low_cnt++;
    for (int t = 0; t < 3; t++) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b0, acc);
      if (!last_ready) low_cnt++;
    end
    check("t3_ready_low", 64'(low_cnt), 64'(1));
    drain();

    // Flush with an empty assembler.
    if (PKCS) want.push_back(64'h0808080808080808);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, acc);
    idle(2, 1'b0);
    check("t4_count", 64'(fifo_count), 64'(PKCS ? 1 : 0));
    drain();

    // FIFO full, then 2 bytes and flush: padded block waits for the first pop.
    for (int k = 0; k < 4; k++) want.push_back(mk_block(8'(8'h40 + 8 * k)));
    want.push_back(PKCS ? 64'hC1C2060606060606 : 64'hC1C2000000000000);
    for (int i = 0; i < 32; i++) send(8'(8'h40 + i), 1'b0);
    send(8'hC1, 1'b0);
    send(8'hC2, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, acc);
    idle(3, 1'b0);
    check("t5_held", 64'(fifo_count), 64'(DEPTH));
    idle(1, 1'b1);
    check("t5_after_pop", 64'(fifo_count), 64'(DEPTH - 1));
    idle(1, 1'b0);
    check("t5_pushed", 64'(fifo_count), 64'(DEPTH));
    drain();

    // Reset mid-block with blocks queued, then a clean block.
    for (int i = 0; i < 21; i++) send(8'(8'h80 + i), 1'b0);
    do_reset();
    want.push_back(mk_block(8'h31));
    for (int i = 0; i < 8; i++) send(8'(8'h31 + i), 1'b1);
    drain();
    check("want_empty", 64'(want.size()), 64'(0));

    // Random traffic against the model.
    for (int t = 0; t < 1500; t++) begin
      cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 19) == 0),
            1'($urandom_range(0, 2) != 0), acc);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
